abm_streamer: RTL and testbench

//  Downstream consumer of the ABM RAM loaded by the PCI->ABM loader. On start, it reads the whole ABM image

---
 rtl/abm_streamer.sv | 219 +++++++++++++++++++++
 tb/tb_abm_streamer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abm_streamer.sv
// ---------------------------------------------------------------------------
// abm_streamer
//
// Purpose:
//   Reads the complete ABM image through a read-only AXI4 master using fixed
//   INCR bursts. Every read beat is forwarded unchanged, in order, to an
//   AXI4-Stream master as a single frame. TLAST marks the final beat. A frame
//   is only started when the loader is not busy.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              one-cycle pulse requesting one frame
//   abm_busy           loader owns the ABM RAM; start is ignored while high
//   idle               high when no frame is in progress
//   error              sticky, some beat of the current/last frame had RRESP!=0
//   frames_sent        completed frame counter (wraps)
//   ABM_AXI_AR*        AXI4 read address channel (master)
//   ABM_AXI_R*         AXI4 read data channel (master)
//   AXIS_*             AXI4-Stream master carrying the frame
// ---------------------------------------------------------------------------
module abm_streamer #(
  parameter int unsigned      DW          = 512,
  parameter int unsigned      AW          = 64,
  parameter logic [AW-1:0]    BASE_ADDR   = '0,
  parameter int unsigned      ABM_BYTES   = 32'h10_0000,
  parameter int unsigned      BURST_BYTES = 4096,
  parameter int unsigned      MAX_OUTSTND = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abm_busy,
  output logic          idle,
  output logic          error,
  output logic [31:0]   frames_sent,
  // AXI4 read address channel
  output logic [AW-1:0] ABM_AXI_ARADDR,
  output logic          ABM_AXI_ARVALID,
  output logic [7:0]    ABM_AXI_ARLEN,
  output logic [2:0]    ABM_AXI_ARSIZE,
  output logic [1:0]    ABM_AXI_ARBURST,
  output logic [3:0]    ABM_AXI_ARID,
  output logic          ABM_AXI_ARLOCK,
  output logic [3:0]    ABM_AXI_ARCACHE,
  output logic [2:0]    ABM_AXI_ARPROT,
  output logic [3:0]    ABM_AXI_ARQOS,
  input  logic          ABM_AXI_ARREADY,
  // AXI4 read data channel
  input  logic [DW-1:0] ABM_AXI_RDATA,
  input  logic          ABM_AXI_RVALID,
  input  logic [1:0]    ABM_AXI_RRESP,
  input  logic          ABM_AXI_RLAST,
  output logic          ABM_AXI_RREADY,
  // AXI4-Stream master
  output logic [DW-1:0] AXIS_TDATA,
  output logic          AXIS_TVALID,
  output logic          AXIS_TLAST,
  input  logic          AXIS_TREADY
);

  localparam int unsigned BEAT_BYTES      = DW / 8;
  localparam int unsigned BEATS_PER_BURST = BURST_BYTES / BEAT_BYTES;
  localparam int unsigned NB              = ABM_BYTES / BURST_BYTES;
  localparam int unsigned NBEAT           = ABM_BYTES / BEAT_BYTES;
  localparam int unsigned IW              = $clog2(NB + 1);
  localparam int unsigned BW              = $clog2(NBEAT + 1);

  localparam logic [IW-1:0] NB_C      = IW'(NB);
  localparam logic [BW-1:0] NBEAT_C   = BW'(NBEAT);
  localparam logic [3:0]    MAXOUT_C  = 4'(MAX_OUTSTND);
  localparam logic [7:0]    ARLEN_C   = 8'(BEATS_PER_BURST - 1);
  localparam logic [2:0]    ARSIZE_C  = 3'($clog2(BEAT_BYTES));
  localparam logic [AW-1:0] BSTEP_C   = AW'(BURST_BYTES);

  // Parameter legality. Requiring BURST_BYTES to divide 4KB and BASE_ADDR to
  // be burst aligned guarantees no burst ever straddles a 4KB boundary.
  if (DW < 32 || (DW & (DW - 1)) != 0) begin : g_bad_dw
    $error("abm_streamer: DW must be a power of two >= 32");
  end
  if (BEAT_BYTES == 0 || (BURST_BYTES % BEAT_BYTES) != 0 ||
      BEATS_PER_BURST < 1 || BEATS_PER_BURST > 256) begin : g_bad_burst
    $error("abm_streamer: BURST_BYTES/(DW/8) must be an integer in 1..256");
  end
  if (BURST_BYTES == 0 || ABM_BYTES == 0 || (ABM_BYTES % BURST_BYTES) != 0) begin : g_bad_abm
    $error("abm_streamer: ABM_BYTES must be a non-zero multiple of BURST_BYTES");
  end
  if (BURST_BYTES == 0 || (4096 % BURST_BYTES) != 0 ||
      (BASE_ADDR % BURST_BYTES) != 0) begin : g_bad_4k
    $error("abm_streamer: bursts would cross a 4KB boundary");
  end
  if (MAX_OUTSTND < 1 || MAX_OUTSTND > 15) begin : g_bad_outstnd
    $error("abm_streamer: MAX_OUTSTND must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e          state_q;
  logic            idle_q;
  logic            error_q;
  logic [31:0]     frames_q;
  logic [AW-1:0]   araddr_q;
  logic [IW-1:0]   issued_q;
  logic [3:0]      outstnd_q;
  logic [BW-1:0]   beats_left_q;
  logic [1:0]      rst_sync_q;
  logic            rst_n_int;

  logic            active;
  logic            arvalid;
  logic            ar_fire;
  logic            r_fire;
  logic            rlast_fire;
  logic            final_beat;

  // Assertion is immediate, release is synchronised to clk so all state
  // flops leave reset on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  assign active     = (state_q != S_IDLE);
  assign arvalid    = (state_q == S_RUN) && (issued_q < NB_C) && (outstnd_q < MAXOUT_C);
  assign ar_fire    = arvalid && ABM_AXI_ARREADY;
  assign r_fire     = active && ABM_AXI_RVALID && AXIS_TREADY;
  assign rlast_fire = r_fire && ABM_AXI_RLAST;
  assign final_beat = active && (beats_left_q == BW'(1));

  // Control FSM and all frame bookkeeping. ARVALID only rises or holds while
  // in RUN: outstnd can only fall between handshakes and issued only moves on
  // a handshake, so the request stays stable until ARREADY.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= S_IDLE;
      idle_q       <= 1'b1;
      error_q      <= 1'b0;
      frames_q     <= '0;
      araddr_q     <= BASE_ADDR;
      issued_q     <= '0;
      outstnd_q    <= '0;
      beats_left_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abm_busy) begin
            state_q      <= S_RUN;
            idle_q       <= 1'b0;
            error_q      <= 1'b0;
            araddr_q     <= BASE_ADDR;
            issued_q     <= '0;
            outstnd_q    <= '0;
            beats_left_q <= NBEAT_C;
          end
        end

        default: begin
          if (ar_fire) begin
            araddr_q <= araddr_q + BSTEP_C;
            issued_q <= issued_q + IW'(1);
            if (issued_q == NB_C - IW'(1)) begin
              state_q <= S_DRAIN;
            end
          end

          // A request and a burst completion in the same cycle cancel out.
          if (ar_fire && !rlast_fire) begin
            outstnd_q <= outstnd_q + 4'd1;
          end else if (!ar_fire && rlast_fire) begin
            outstnd_q <= outstnd_q - 4'd1;
          end

          if (r_fire) begin
            beats_left_q <= beats_left_q - BW'(1);
            if (ABM_AXI_RRESP != 2'b00) begin
              error_q <= 1'b1;
            end
            if (final_beat) begin
              frames_q <= frames_q + 32'd1;
              state_q  <= S_IDLE;
              idle_q   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign idle        = idle_q;
  assign error       = error_q;
  assign frames_sent = frames_q;

  assign ABM_AXI_ARADDR  = araddr_q;
  assign ABM_AXI_ARVALID = arvalid;
  assign ABM_AXI_ARLEN   = ARLEN_C;
  assign ABM_AXI_ARSIZE  = ARSIZE_C;
  assign ABM_AXI_ARBURST = 2'b01;
  assign ABM_AXI_ARID    = 4'd0;
  assign ABM_AXI_ARLOCK  = 1'b0;
  assign ABM_AXI_ARCACHE = 4'd0;
  assign ABM_AXI_ARPROT  = 3'd0;
  assign ABM_AXI_ARQOS   = 4'd0;

  // Zero-latency pass-through; outside a frame nothing is consumed, so stray
  // R beats stay on the bus.
  assign AXIS_TDATA     = ABM_AXI_RDATA;
  assign AXIS_TVALID    = active && ABM_AXI_RVALID;
  assign ABM_AXI_RREADY = active && AXIS_TREADY;
  assign AXIS_TLAST     = final_beat;

endmodule

// File: tb/tb_abm_streamer.sv
// ---------------------------------------------------------------------------
// tb_abm_streamer
//
// Directed bench for abm_streamer with a reduced 64KB image (16 bursts of
// 64 beats at DW=512). A reactive AXI read slave backs the ABM RAM with an
// address-derived pattern; a monitor tracks beats, requests and outstanding
// bursts; the main initial block runs the directed steps and checks.
// ---------------------------------------------------------------------------
module tb_abm_streamer;

  localparam int unsigned DW          = 512;
  localparam int unsigned AW          = 64;
  localparam int unsigned ABM_BYTES   = 32'h1_0000;
  localparam int unsigned BURST_BYTES = 4096;
  localparam int unsigned BEAT_BYTES  = DW / 8;
  localparam int unsigned NB          = ABM_BYTES / BURST_BYTES;
  localparam int unsigned NBEAT       = ABM_BYTES / BEAT_BYTES;
  localparam logic [AW-1:0] BASE      = '0;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          abm_busy;
  logic          idle;
  logic          error;
  logic [31:0]   frames_sent;
  logic [AW-1:0] ABM_AXI_ARADDR;
  logic          ABM_AXI_ARVALID;
  logic [7:0]    ABM_AXI_ARLEN;
  logic [2:0]    ABM_AXI_ARSIZE;
  logic [1:0]    ABM_AXI_ARBURST;
  logic [3:0]    ABM_AXI_ARID;
  logic          ABM_AXI_ARLOCK;
  logic [3:0]    ABM_AXI_ARCACHE;
  logic [2:0]    ABM_AXI_ARPROT;
  logic [3:0]    ABM_AXI_ARQOS;
  logic          ABM_AXI_ARREADY;
  logic [DW-1:0] ABM_AXI_RDATA;
  logic          ABM_AXI_RVALID;
  logic [1:0]    ABM_AXI_RRESP;
  logic          ABM_AXI_RLAST;
  logic          ABM_AXI_RREADY;
  logic [DW-1:0] AXIS_TDATA;
  logic          AXIS_TVALID;
  logic          AXIS_TLAST;
  logic          AXIS_TREADY;

  abm_streamer #(
    .DW(DW), .AW(AW), .BASE_ADDR(BASE), .ABM_BYTES(ABM_BYTES),
    .BURST_BYTES(BURST_BYTES), .MAX_OUTSTND(2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .abm_busy(abm_busy),
    .idle(idle), .error(error), .frames_sent(frames_sent),
    .ABM_AXI_ARADDR(ABM_AXI_ARADDR), .ABM_AXI_ARVALID(ABM_AXI_ARVALID),
    .ABM_AXI_ARLEN(ABM_AXI_ARLEN), .ABM_AXI_ARSIZE(ABM_AXI_ARSIZE),
    .ABM_AXI_ARBURST(ABM_AXI_ARBURST), .ABM_AXI_ARID(ABM_AXI_ARID),
    .ABM_AXI_ARLOCK(ABM_AXI_ARLOCK), .ABM_AXI_ARCACHE(ABM_AXI_ARCACHE),
    .ABM_AXI_ARPROT(ABM_AXI_ARPROT), .ABM_AXI_ARQOS(ABM_AXI_ARQOS),
    .ABM_AXI_ARREADY(ABM_AXI_ARREADY),
    .ABM_AXI_RDATA(ABM_AXI_RDATA), .ABM_AXI_RVALID(ABM_AXI_RVALID),
    .ABM_AXI_RRESP(ABM_AXI_RRESP), .ABM_AXI_RLAST(ABM_AXI_RLAST),
    .ABM_AXI_RREADY(ABM_AXI_RREADY),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID),
    .AXIS_TLAST(AXIS_TLAST), .AXIS_TREADY(AXIS_TREADY)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case some bounded wait is ever mis-sized.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int vecCount  = 0;
  int missCount = 0;

  // Slave behaviour knobs, set by the directed sequence.
  int          arDelayMax  = 0;
  int          slaveLat    = 0;
  bit          treadyRandom = 1'b0;
  bit          treadyFixed  = 1'b1;
  bit          errInject    = 1'b0;
  logic [63:0] errAddr      = '0;
  bit          strayValid   = 1'b0;

  // Handshake snapshot taken by the monitor at the falling edge.
  bit          arFireS, rFireS, arValidS;
  logic [63:0] arAddrS;
  logic [7:0]  arLenS;

  // Per-frame statistics accumulated by the monitor.
  int          beatCount, dataErr, tlastErr, arCount, arAddrErr, arFieldErr;
  int          stableErr, errLateCnt, errBeats, tbOutstanding, maxOutstanding;
  logic [63:0] firstArAddr, stallAddr;
  bit          arStallPrev, errPrev;

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          readyCycle;
  } burstT;

  // RAM content of the ABM image: every 32-bit lane derived from the beat
  // address, so any reordering, loss or duplication changes the data.
  function automatic logic [DW-1:0] ramWord(input logic [63:0] addr);
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) begin
      w[i*32 +: 32] = addr[31:0] ^ (32'h5A00_0000 + 32'(i) * 32'h0101_0011);
    end
    return w;
  endfunction

  // Reactive AXI read slave. It updates just after each rising edge using
  // the handshakes the monitor saw at the preceding falling edge; bursts are
  // returned in order after slaveLat cycles.
  initial begin
    burstT       arQ[$];
    int          beatIdx;
    int          arWait;
    int          cycleCnt;
    logic [63:0] a;
    beatIdx  = 0;
    arWait   = 0;
    cycleCnt = 0;
    ABM_AXI_ARREADY = 1'b1;
    ABM_AXI_RVALID  = 1'b0;
    ABM_AXI_RDATA   = '0;
    ABM_AXI_RRESP   = 2'b00;
    ABM_AXI_RLAST   = 1'b0;
    AXIS_TREADY     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cycleCnt++;
      if (!resetn) begin
        arQ.delete();
        beatIdx = 0;
        arWait  = 0;
      end else begin
        if (rFireS && arQ.size() > 0) begin
          if (beatIdx == arQ[0].len) begin
            void'(arQ.pop_front());
            beatIdx = 0;
          end else begin
            beatIdx++;
          end
        end
        if (arFireS) begin
          arQ.push_back('{arAddrS, int'(arLenS), cycleCnt + slaveLat});
          arWait = $urandom_range(0, arDelayMax);
        end else if (arValidS && arWait > 0) begin
          arWait--;
        end
      end
      ABM_AXI_ARREADY = (arWait == 0);
      AXIS_TREADY     = treadyRandom ? 1'($urandom_range(0, 1)) : treadyFixed;
      if (arQ.size() > 0 && arQ[0].readyCycle <= cycleCnt) begin
        a = arQ[0].addr + 64'(beatIdx) * 64'(BEAT_BYTES);
        ABM_AXI_RVALID = 1'b1;
        ABM_AXI_RDATA  = ramWord(a);
        ABM_AXI_RLAST  = (beatIdx == arQ[0].len);
        ABM_AXI_RRESP  = (errInject && a == errAddr) ? 2'b10 : 2'b00;
      end else begin
        ABM_AXI_RVALID = strayValid;
        ABM_AXI_RDATA  = ramWord(64'hDEAD_0000);
        ABM_AXI_RLAST  = 1'b0;
        ABM_AXI_RRESP  = 2'b00;
      end
    end
  end

  // Monitor: at each falling edge record the handshakes about to complete and
  // accumulate per-frame statistics against the expected image and address
  // sequence.
  always @(negedge clk) begin
    arFireS  = ABM_AXI_ARVALID && ABM_AXI_ARREADY;
    rFireS   = ABM_AXI_RVALID && ABM_AXI_RREADY;
    arValidS = ABM_AXI_ARVALID;
    arAddrS  = ABM_AXI_ARADDR;
    arLenS   = ABM_AXI_ARLEN;
    if (!resetn) begin
      tbOutstanding = 0;
      arStallPrev   = 1'b0;
      errPrev       = 1'b0;
    end else begin
      if (arStallPrev && (ABM_AXI_ARVALID !== 1'b1 || ABM_AXI_ARADDR !== stallAddr)) begin
        stableErr++;
      end
      arStallPrev = ABM_AXI_ARVALID && !ABM_AXI_ARREADY;
      stallAddr   = ABM_AXI_ARADDR;
      if (arFireS) begin
        if (arCount == 0) firstArAddr = ABM_AXI_ARADDR;
        if (ABM_AXI_ARADDR !== BASE + 64'(arCount) * 64'(BURST_BYTES)) arAddrErr++;
        if (ABM_AXI_ARLEN !== 8'd63 || ABM_AXI_ARSIZE !== 3'd6 || ABM_AXI_ARBURST !== 2'b01 ||
            ABM_AXI_ARID !== 4'd0 || ABM_AXI_ARLOCK !== 1'b0 || ABM_AXI_ARCACHE !== 4'd0 ||
            ABM_AXI_ARPROT !== 3'd0 || ABM_AXI_ARQOS !== 4'd0) begin
          arFieldErr++;
        end
        arCount++;
        tbOutstanding++;
      end
      if (rFireS && ABM_AXI_RLAST) tbOutstanding--;
      if (tbOutstanding > maxOutstanding) maxOutstanding = tbOutstanding;
      if (errPrev && error !== 1'b1) errLateCnt++;
      errPrev = rFireS && (ABM_AXI_RRESP != 2'b00);
      if (AXIS_TVALID && AXIS_TREADY) begin
        if (AXIS_TDATA !== ramWord(BASE + 64'(beatCount) * 64'(BEAT_BYTES))) dataErr++;
        if (AXIS_TLAST !== (beatCount == NBEAT - 1)) tlastErr++;
        if (ABM_AXI_RRESP != 2'b00) errBeats++;
        beatCount++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Settle point for checks: just after the falling edge, once the monitor
  // has run.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearFrameStats();
    beatCount = 0; dataErr = 0; tlastErr = 0; arCount = 0; arAddrErr = 0;
    arFieldErr = 0; stableErr = 0; errLateCnt = 0; errBeats = 0;
    maxOutstanding = 0; firstArAddr = '1;
  endtask

  // One-cycle start pulse, launched just after a rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitFrameDone(input int maxCycles);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("frame_done_in_time", idle, 1'b1);
  endtask

  task automatic checkFrame(input string name, input logic [31:0] expFrames);
    $display("[TB] checking frame %s", name);
    checkOutput({name, "_beats"},       beatCount, NBEAT);
    checkOutput({name, "_data_err"},    dataErr, 0);
    checkOutput({name, "_tlast_err"},   tlastErr, 0);
    checkOutput({name, "_ar_count"},    arCount, NB);
    checkOutput({name, "_ar_addr_err"}, arAddrErr, 0);
    checkOutput({name, "_ar_fields"},   arFieldErr, 0);
    checkOutput({name, "_ar_stable"},   stableErr, 0);
    checkOutput({name, "_outstnd_le2"}, (maxOutstanding <= 2), 1'b1);
    checkOutput({name, "_frames_sent"}, frames_sent, expFrames);
  endtask

  initial begin
    int bad;
    int n;
    resetn   = 1'b0;
    start    = 1'b0;
    abm_busy = 1'b0;
    clearFrameStats();

    // Reset state, with TREADY high and nothing consumed.
    repeat (3) tick();
    checkOutput("rst_idle",        idle, 1'b1);
    checkOutput("rst_arvalid",     ABM_AXI_ARVALID, 1'b0);
    checkOutput("rst_rready",      ABM_AXI_RREADY, 1'b0);
    checkOutput("rst_tvalid",      AXIS_TVALID, 1'b0);
    checkOutput("rst_tlast",       AXIS_TLAST, 1'b0);
    checkOutput("rst_error",       error, 1'b0);
    checkOutput("rst_frames_sent", frames_sent, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) tick();

    // A stray R beat while idle must not be accepted or forwarded.
    strayValid = 1'b1;
    repeat (10) tick();
    checkOutput("stray_rready", ABM_AXI_RREADY, 1'b0);
    checkOutput("stray_tvalid", AXIS_TVALID, 1'b0);
    checkOutput("stray_beats",  beatCount, 0);
    strayValid = 1'b0;
    repeat (2) tick();

    // Full frame with an always-ready slave and sink.
    clearFrameStats();
    applyStimulus();
    tick();
    checkOutput("f1_idle_drop", idle, 1'b0);
    waitFrameDone(20000);
    checkFrame("f1", 32'd1);
    checkOutput("f1_first_araddr", firstArAddr, 64'h0);
    checkOutput("f1_error", error, 1'b0);

    // Start while the loader is busy is ignored.
    clearFrameStats();
    abm_busy = 1'b1;
    applyStimulus();
    bad = 0;
    repeat (100) begin
      tick();
      if (ABM_AXI_ARVALID !== 1'b0 || idle !== 1'b1) bad++;
    end
    checkOutput("busy_ignored", bad, 0);
    abm_busy = 1'b0;
    applyStimulus();
    tick();
    checkOutput("f2_idle_drop", idle, 1'b0);
    waitFrameDone(20000);
    checkFrame("f2", 32'd2);

    // Back-pressure on both sides plus a start pulse in mid-frame.
    clearFrameStats();
    arDelayMax   = 7;
    slaveLat     = 20;
    treadyRandom = 1'b1;
    applyStimulus();
    repeat (200) tick();
    applyStimulus();
    waitFrameDone(40000);
    checkFrame("f3", 32'd3);
    checkOutput("f3_outstnd_max", maxOutstanding, 2);
    arDelayMax   = 0;
    slaveLat     = 0;
    treadyRandom = 1'b0;
    repeat (5) tick();

    // Error response on one beat: sticky flag, frame still complete.
    clearFrameStats();
    errInject = 1'b1;
    errAddr   = 64'(100 * BEAT_BYTES);
    applyStimulus();
    tick();
    checkOutput("f4_error_start", error, 1'b0);
    waitFrameDone(20000);
    checkFrame("f4", 32'd4);
    checkOutput("f4_error_sticky", error, 1'b1);
    checkOutput("f4_error_late",   errLateCnt, 0);
    checkOutput("f4_error_beats",  errBeats, 1);
    errInject = 1'b0;
    repeat (5) tick();

    // Next frame clears error; reset hits it mid-frame.
    clearFrameStats();
    applyStimulus();
    tick();
    checkOutput("f5_error_cleared", error, 1'b0);
    n = 0;
    while (beatCount < 500 && n < 5000) begin
      tick();
      n++;
    end
    checkOutput("f5_reached_beat500", (beatCount >= 500), 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_idle",    idle, 1'b1);
    checkOutput("mid_rst_arvalid", ABM_AXI_ARVALID, 1'b0);
    checkOutput("mid_rst_rready",  ABM_AXI_RREADY, 1'b0);
    checkOutput("mid_rst_tvalid",  AXIS_TVALID, 1'b0);
    checkOutput("mid_rst_tlast",   AXIS_TLAST, 1'b0);
    checkOutput("mid_rst_frames",  frames_sent, 32'd0);
    checkOutput("mid_rst_error",   error, 1'b0);
    repeat (3) tick();
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) tick();

    clearFrameStats();
    applyStimulus();
    waitFrameDone(20000);
    checkFrame("f6", 32'd1);
    checkOutput("f6_first_araddr", firstArAddr, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
